// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: time-field widths, limits and default clock rates.
// Used by both the stopwatch datapath and the stopwatch control unit.
package stopwatch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    localparam int DEF_CLK_HZ  = 100_000_000;
    localparam int DEF_TICK_HZ = 100;

    // Complete time-of-count value, used for the next-state bundle.
    typedef struct packed {
        logic [MSEC_W-1:0] msec;
        logic [SEC_W-1:0]  sec;
        logic [MIN_W-1:0]  min;
        logic [HOUR_W-1:0] hour;
    } sw_time_t;

endpackage

// File: rtl/tick_gen_100hz.sv
// Prescaler producing a one-cycle registered tick every CLK_HZ/TICK_HZ enabled
// clocks. The count holds while disabled, so a stop/resume keeps the partial period.
module tick_gen_100hz
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int              DIV  = CLK_HZ / TICK_HZ;
    localparam int              PW   = $clog2(DIV);
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick_reg;

    // Prescaler count and tick pulse; clear wins over enable and drops a pending tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt  <= '0;
            tick_reg <= 1'b0;
        end else if (i_clear) begin
            pre_cnt  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= i_en && (pre_cnt == LAST);
            if (i_en) begin
                pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
            end
        end
    end

    assign o_tick = tick_reg;

endmodule

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: 1/100 s tick generation plus the cascaded
// hundredths/seconds/minutes/hours wrap counters feeding the display mux.
module stopwatch_dp
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_runstop,
    input  logic              i_clear,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick
);

    logic              tick;
    logic [MSEC_W-1:0] msec_q;
    logic [SEC_W-1:0]  sec_q;
    logic [MIN_W-1:0]  min_q;
    logic [HOUR_W-1:0] hour_q;
    sw_time_t          time_d;

    tick_gen_100hz #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .i_en    (i_runstop),
        .i_clear (i_clear),
        .o_tick  (tick)
    );

    // Next time value: ripple the carries combinationally so every field moves on one edge.
    always_comb begin
        time_d.msec = msec_q;
        time_d.sec  = sec_q;
        time_d.min  = min_q;
        time_d.hour = hour_q;
        if (tick) begin
            if (msec_q == MSEC_MAX) begin
                time_d.msec = '0;
                if (sec_q == SEC_MAX) begin
                    time_d.sec = '0;
                    if (min_q == MIN_MAX) begin
                        time_d.min  = '0;
                        time_d.hour = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
                    end else begin
                        time_d.min = min_q + 1'b1;
                    end
                end else begin
                    time_d.sec = sec_q + 1'b1;
                end
            end else begin
                time_d.msec = msec_q + 1'b1;
            end
        end
    end

    // Time-field registers; clear overrides any tick arriving on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else if (i_clear) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            msec_q <= time_d.msec;
            sec_q  <= time_d.sec;
            min_q  <= time_d.min;
            hour_q <= time_d.hour;
        end
    end

    assign o_msec = msec_q;
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;
    assign o_tick = tick;

endmodule

// File: doc/stopwatch_dp.md
# stopwatch_dp

Stopwatch datapath, directly downstream of the stopwatch control unit. It consumes the control unit's level outputs: run/stop is high while in RUN, and clear is high while in CLEAR. From the system clock it generates a 1/100-second tick and advances a cascaded hundredths/seconds/minutes/hours counter. The counter values feed the FND display mux.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- TICK_HZ, 100, counting resolution in Hz; DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- i_runstop  input  1  level; 1 = count, 0 = hold
- i_clear  input  1  level; 1 = zero all state
- o_msec  output  7  hundredths, 0..99
- o_sec  output  6  seconds, 0..59
- o_min  output  6  minutes, 0..59
- o_hour  output  5  hours, 0..23
- o_tick  output  1  one-cycle pulse per accepted 1/100 s tick

## Operation
- Prescaler: counter of width $clog2(DIV), range 0..DIV-1.
  - Increments by 1 on each clock while i_runstop=1 and i_clear=0.
  - On reaching DIV-1 it wraps to 0 and sets tick_reg=1 for the next cycle.
  - Holds its value while i_runstop=0, so stop/resume loses no partial period.
- o_tick is tick_reg, a registered pulse.
- Time counters advance on the edge where tick_reg=1:
  - msec increments. At 99 it wraps to 0 and carries to sec.
  - sec wraps 59→0 and carries to min.
  - min wraps 59→0 and carries to hour.
  - hour wraps 23→0; all fields roll over to 00:00:00.00.
- Carries are combinational within the same edge, so all fields update simultaneously.
- Clear takes priority over everything. While i_clear=1, on every edge:
  - prescaler, tick_reg and all time fields go to 0;
  - a pending tick_reg is discarded.
- i_runstop=1 and i_clear=1 together behave as clear; the control unit never produces this, but the block must tolerate it.
- Stop while tick_reg=1: that tick is still applied to the counters; no further prescaler advance.
- Values outside the legal ranges are unreachable. Arithmetic uses exact field widths with no saturation.

## Timing
- Reset (rst=0) sets every output and internal register to 0 immediately, without waiting for a clock edge.
- First tick after reset release with i_runstop held at 1 from the first edge:
  - prescaler reaches DIV-1 after DIV-1 edges;
  - wraps on edge DIV;
  - o_tick is high during the cycle after edge DIV;
  - o_msec=1 after edge DIV+1.
- Steady state: one o_tick pulse and one msec increment every DIV cycles of run time.
- Counter latency: one cycle from prescaler wrap to counter update.
- Clear latency: one edge.
- Reset deasserting mid-count restarts from zero. No synchronizer is required for rst release beyond the team's standard reset bridge at top level.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package (stopwatch_pkg) holds:
  - the field limits MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - the field widths;
  - the default CLK_HZ/TICK_HZ.
- The stopwatch control unit reuses the same package.
- One sub-module, tick_gen_100hz, contains the prescaler and tick_reg, with ports clk, rst, i_en, i_clear, o_tick.
- The cascade of four wrap counters stays in stopwatch_dp.

## Test plan
Benches use CLK_HZ=1000, TICK_HZ=100 (DIV=10) unless noted.
- Reset: hold rst=0 for 3 cycles with random inputs → all outputs 0; outputs go to 0 asynchronously on rst fall, mid-cycle.
- Basic count: release rst, i_runstop=1 → o_tick high in cycle 11; o_msec=1 after edge 11, =2 after edge 21; run 1000 cycles → o_msec=99 with o_sec=0; one more tick → o_msec=0, o_sec=1.
- Stop/resume:
  - drop i_runstop after 5 run edges and hold 50 cycles → o_msec and the prescaler unchanged;
  - resume → next tick after exactly 5 more run edges.
- Clear priority:
  - counting at 00:00:03.42, assert i_clear=1 with i_runstop=1 for 1 cycle → all fields 0 next edge, o_tick=0;
  - release clear → first tick after 10 more run edges.
- Rollover: use CLK_HZ=200, TICK_HZ=100 (DIV=2) → after 23:59:59.99 the next tick gives 00:00:00.00, with all fields changing on the same edge.
- Stop on tick cycle: deassert i_runstop in the cycle where o_tick=1 → that increment is applied; no further increments.
